frame_update_sequencer: RTL

Per-frame scheduler for the game datapath. On each accepted frame-start pulse from the VGA timing side, it issues one-cycle step strobes to the paddle, ball and brick update blocks in fixed order, and waits for each block's done handshake before starting the next. Frame dividers set how often the ball and the bricks advance, so all game-state updates fall inside vertical blank and never overlap. It sits between the top-level game FSM (which drives `enable` in PLAY) and the object modules.

---
 rtl/frame_update_sequencer_pkg.sv | 19 +
 rtl/frame_update_sequencer_divider.sv | 28 ++
 rtl/frame_update_sequencer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/frame_update_sequencer_pkg.sv
// Shared definitions for the per-frame game update sequencer.
// Holds the sequencer state encoding and the default frame-divider and timeout settings.
package frame_update_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        STEP_P,
        WAIT_P,
        STEP_B,
        WAIT_B,
        STEP_K,
        WAIT_K
    } seq_state_t;

    localparam int BALL_DIV_DEF  = 1;
    localparam int BRICK_DIV_DEF = 60;
    localparam int TIMEOUT_DEF   = 1023;

endpackage

// File: rtl/frame_update_sequencer_divider.sv
// Frame divider: reports "due" on every DIV-th tick.
// The count advances on each tick and wraps to zero on the tick where it was due.
module frame_divider #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    output logic due
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    // Due is judged on the count before this tick, so the first due tick is tick number DIV.
    assign due = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= due ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/frame_update_sequencer.sv
// Per-frame scheduler: strobes paddle, ball and brick updates in order during vertical blank,
// waiting on each done handshake (with a timeout) before moving on.
module frame_update_sequencer
    import frame_update_sequencer_pkg::*;
#(
    parameter int BALL_DIV  = BALL_DIV_DEF,
    parameter int BRICK_DIV = BRICK_DIV_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        frame_start,
    input  logic        clear_err,
    output logic        paddle_step,
    input  logic        paddle_done,
    output logic        ball_step,
    input  logic        ball_done,
    output logic        brick_step,
    input  logic        brick_done,
    output logic        busy,
    output logic        overrun,
    output logic        timeout_err,
    output logic [15:0] frame_count
);

    localparam int TW = ($clog2(TIMEOUT + 1) > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT);

    seq_state_t    state;
    seq_state_t    next_state;
    logic [TW-1:0] wait_cnt;
    logic          ball_due_now;
    logic          brick_due_now;
    logic          ball_due;
    logic          brick_due;
    logic          accept;
    logic          drop;
    logic          in_wait;
    logic          done_sel;
    logic          wait_expired;
    logic          wait_exit;
    logic          timeout_evt;
    logic          paddle_step_d;
    logic          ball_step_d;
    logic          brick_step_d;
    logic          busy_d;

    assign accept       = (state == IDLE) && frame_start && enable;
    assign drop         = (state != IDLE) && frame_start;
    assign in_wait      = state inside {WAIT_P, WAIT_B, WAIT_K};
    assign wait_expired = (wait_cnt == WAIT_LAST);
    assign wait_exit    = in_wait && (done_sel || wait_expired);
    assign timeout_evt  = in_wait && !done_sel && wait_expired;

    frame_divider #(.DIV(BALL_DIV)) u_ball_div (
        .clk  (clk),
        .rst  (rst),
        .tick (accept),
        .due  (ball_due_now)
    );

    frame_divider #(.DIV(BRICK_DIV)) u_brick_div (
        .clk  (clk),
        .rst  (rst),
        .tick (accept),
        .due  (brick_due_now)
    );

    always_comb begin
        done_sel = 1'b0;
        case (state)
            WAIT_P:  done_sel = paddle_done;
            WAIT_B:  done_sel = ball_done;
            WAIT_K:  done_sel = brick_done;
            default: done_sel = 1'b0;
        endcase
    end

    // Strobes and busy are decoded from the next state and registered alongside it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            ball_due    <= 1'b0;
            brick_due   <= 1'b0;
            paddle_step <= 1'b0;
            ball_step   <= 1'b0;
            brick_step  <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
            frame_count <= '0;
        end else begin
            state       <= next_state;
            paddle_step <= paddle_step_d;
            ball_step   <= ball_step_d;
            brick_step  <= brick_step_d;
            busy        <= busy_d;
            if (accept) begin
                frame_count <= frame_count + 16'd1;
                ball_due    <= ball_due_now;
                brick_due   <= brick_due_now;
            end
            if (state inside {STEP_P, STEP_B, STEP_K}) begin
                wait_cnt <= TW'(1);
            end else if (in_wait && !wait_exit) begin
                wait_cnt <= wait_cnt + TW'(1);
            end
            if (drop) begin
                overrun <= 1'b1;
            end else if (clear_err) begin
                overrun <= 1'b0;
            end
            if (timeout_evt) begin
                timeout_err <= 1'b1;
            end else if (clear_err) begin
                timeout_err <= 1'b0;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (accept) next_state = STEP_P;
            STEP_P: next_state = WAIT_P;
            WAIT_P: begin
                if (wait_exit) begin
                    if (ball_due)       next_state = STEP_B;
                    else if (brick_due) next_state = STEP_K;
                    else                next_state = IDLE;
                end
            end
            STEP_B: next_state = WAIT_B;
            WAIT_B: begin
                if (wait_exit) next_state = brick_due ? STEP_K : IDLE;
            end
            STEP_K: next_state = WAIT_K;
            WAIT_K: if (wait_exit) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        paddle_step_d = (next_state == STEP_P);
        ball_step_d   = (next_state == STEP_B);
        brick_step_d  = (next_state == STEP_K);
        busy_d        = (next_state != IDLE);
    end

endmodule
